// File: rtl/sdp_brdma_pkg.sv
// -----------------------------------------------------------------------------
// sdp_brdma_pkg
// Shared constants for the SDP bias-read DMA egress slice.
//   - context field positions for the 16-bit context-queue entry
//   - egress FSM state encoding
//   - default response/output data width
// -----------------------------------------------------------------------------
package sdp_brdma_pkg;

  localparam int DW_DEFAULT    = 512;

  // Context layout: [11:0] beats-1, [14:12] reserved, [15] last request of layer
  localparam int CTX_BEATS_MSB = 11;
  localparam int CTX_LAYER_BIT = 15;
  localparam int BEAT_CNT_W    = CTX_BEATS_MSB + 1;

  localparam int PERF_W        = 32;

  typedef enum logic {
    EG_IDLE   = 1'b0,
    EG_STREAM = 1'b1
  } eg_state_e;

endpackage

// File: rtl/sdp_brdma_eg_pipe.sv
// -----------------------------------------------------------------------------
// sdp_brdma_eg_pipe
// Single-stage valid/ready output register carrying {data, last, layer_end}.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_vld          load strobe; only asserted by the parent when pipe_free
//   in_data/last/layer_end  payload to capture
//   out_rdy         downstream ready
//   pipe_free       register empty or draining this cycle
//   out_vld/out_data/out_last/out_layer_end  registered output
// -----------------------------------------------------------------------------
module sdp_brdma_eg_pipe
  import sdp_brdma_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_layer_end,
  input  logic          out_rdy,
  output logic          pipe_free,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_layer_end
);

  assign pipe_free = !out_vld || out_rdy;

  // Payload only moves on a load, so it is held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld       <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_layer_end <= 1'b0;
    end else if (in_vld) begin
      out_vld       <= 1'b1;
      out_data      <= in_data;
      out_last      <= in_last;
      out_layer_end <= in_layer_end;
    end else if (out_rdy) begin
      out_vld       <= 1'b0;
    end
  end

endmodule

// File: rtl/sdp_brdma_eg_unpack.sv
// -----------------------------------------------------------------------------
// sdp_brdma_eg_unpack
// Egress stage of the SDP bias-read DMA. Pops one context per DMA request
// from the context queue and frames the matching read-response beats,
// tagging the final beat of each request (last) and of each layer
// (layer_end), through a single output register stage.
//
// Optional feature macro: SDP_BRDMA_EG_PERF_EN
//   defined   -> saturating 32-bit accepted-beat and popped-context counters
//   undefined -> eg_perf_beats / eg_perf_ctx tied to 0, no counter flops
//
// Handshake rule on every interface: a transfer happens on a rising clock
// edge where pvld and prdy are both high; a producer holds pvld and pd
// stable until that edge, and no prdy depends on its own interface's pvld.
//
// Ports:
//   nvdla_core_clk, nvdla_core_rstn        clock, async active-low reset
//   cq2eg_pvld/prdy/pd                     context queue pop interface
//   dma_rd_rsp_pvld/prdy/pd                DMA read-response beats
//   eg_out_pvld/prdy/pd/last/layer_end     framed output stream
//   eg_idle                                no context held, output empty
//   eg_perf_beats, eg_perf_ctx             performance counters
// -----------------------------------------------------------------------------
module sdp_brdma_eg_unpack
  import sdp_brdma_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CTX_W = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              cq2eg_pvld,
  output logic              cq2eg_prdy,
  input  logic [CTX_W-1:0]  cq2eg_pd,
  input  logic              dma_rd_rsp_pvld,
  output logic              dma_rd_rsp_prdy,
  input  logic [DW-1:0]     dma_rd_rsp_pd,
  output logic              eg_out_pvld,
  input  logic              eg_out_prdy,
  output logic [DW-1:0]     eg_out_pd,
  output logic              eg_out_last,
  output logic              eg_out_layer_end,
  output logic              eg_idle,
  output logic [PERF_W-1:0] eg_perf_beats,
  output logic [PERF_W-1:0] eg_perf_ctx
);

  eg_state_e             state;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  layer_flag;

  logic pipe_free;
  logic out_vld;
  logic cnt_zero;
  logic beat_acc;
  logic fin;
  logic ctx_pop;

  // Reserved context bits carry no meaning here.
  logic ctx_rsvd_unused;
  assign ctx_rsvd_unused = ^cq2eg_pd[CTX_LAYER_BIT-1:CTX_BEATS_MSB+1];

  assign cnt_zero        = (beat_cnt == '0);
  assign dma_rd_rsp_prdy = (state == EG_STREAM) && pipe_free;
  assign beat_acc        = dma_rd_rsp_pvld && dma_rd_rsp_prdy;
  assign fin             = beat_acc && cnt_zero;
  // Popping on the final beat lets the next request start without a bubble.
  assign cq2eg_prdy      = (state == EG_IDLE) || fin;
  assign ctx_pop         = cq2eg_pvld && cq2eg_prdy;

  // In STREAM a pop can only coincide with fin, so the pop branch also
  // covers the back-to-back hand-over.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state      <= EG_IDLE;
      beat_cnt   <= '0;
      layer_flag <= 1'b0;
    end else if (ctx_pop) begin
      state      <= EG_STREAM;
      beat_cnt   <= cq2eg_pd[CTX_BEATS_MSB:0];
      layer_flag <= cq2eg_pd[CTX_LAYER_BIT];
    end else if (fin) begin
      state      <= EG_IDLE;
    end else if (beat_acc) begin
      beat_cnt   <= beat_cnt - 1'b1;
    end
  end

  sdp_brdma_eg_pipe #(
    .DW (DW)
  ) u_pipe (
    .clk           (nvdla_core_clk),
    .rst_n         (nvdla_core_rstn),
    .in_vld        (beat_acc),
    .in_data       (dma_rd_rsp_pd),
    .in_last       (cnt_zero),
    .in_layer_end  (layer_flag && cnt_zero),
    .out_rdy       (eg_out_prdy),
    .pipe_free     (pipe_free),
    .out_vld       (out_vld),
    .out_data      (eg_out_pd),
    .out_last      (eg_out_last),
    .out_layer_end (eg_out_layer_end)
  );

  assign eg_out_pvld = out_vld;
  assign eg_idle     = (state == EG_IDLE) && !out_vld;

`ifdef SDP_BRDMA_EG_PERF_EN
  logic [PERF_W-1:0] perf_beats_q;
  logic [PERF_W-1:0] perf_ctx_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_beats_q <= '0;
      perf_ctx_q   <= '0;
    end else begin
      if (beat_acc && (perf_beats_q != '1)) perf_beats_q <= perf_beats_q + 1'b1;
      if (ctx_pop  && (perf_ctx_q   != '1)) perf_ctx_q   <= perf_ctx_q + 1'b1;
    end
  end

  assign eg_perf_beats = perf_beats_q;
  assign eg_perf_ctx   = perf_ctx_q;
`else
  assign eg_perf_beats = '0;
  assign eg_perf_ctx   = '0;
`endif

endmodule

// File: tb/tb_sdp_brdma_eg_unpack.sv
// -----------------------------------------------------------------------------
// tb_sdp_brdma_eg_unpack
// Self-checking bench for sdp_brdma_eg_unpack: cycle-exact hand sequences
// for timing corners, a table of contexts streamed under random output
// stalls, and a scoreboard that compares every output beat in order.
// -----------------------------------------------------------------------------
module tb_sdp_brdma_eg_unpack;

  localparam int DW  = 32;
  localparam int EW  = DW + 2;
  localparam int TMO = 20000;

  // ---------------------------------------------------------------- clock/reset
  logic nvdla_core_clk  = 1'b0;
  logic nvdla_core_rstn = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  logic          cq2eg_pvld = 1'b0;
  logic          cq2eg_prdy;
  logic [15:0]   cq2eg_pd   = '0;
  logic          dma_rd_rsp_pvld = 1'b0;
  logic          dma_rd_rsp_prdy;
  logic [DW-1:0] dma_rd_rsp_pd   = '0;
  logic          eg_out_pvld;
  logic          eg_out_prdy = 1'b1;
  logic [DW-1:0] eg_out_pd;
  logic          eg_out_last;
  logic          eg_out_layer_end;
  logic          eg_idle;
  logic [31:0]   eg_perf_beats;
  logic [31:0]   eg_perf_ctx;

  sdp_brdma_eg_unpack #(.DW(DW), .CTX_W(16)) dut (
    .nvdla_core_clk   (nvdla_core_clk),
    .nvdla_core_rstn  (nvdla_core_rstn),
    .cq2eg_pvld       (cq2eg_pvld),
    .cq2eg_prdy       (cq2eg_prdy),
    .cq2eg_pd         (cq2eg_pd),
    .dma_rd_rsp_pvld  (dma_rd_rsp_pvld),
    .dma_rd_rsp_prdy  (dma_rd_rsp_prdy),
    .dma_rd_rsp_pd    (dma_rd_rsp_pd),
    .eg_out_pvld      (eg_out_pvld),
    .eg_out_prdy      (eg_out_prdy),
    .eg_out_pd        (eg_out_pd),
    .eg_out_last      (eg_out_last),
    .eg_out_layer_end (eg_out_layer_end),
    .eg_idle          (eg_idle),
    .eg_perf_beats    (eg_perf_beats),
    .eg_perf_ctx      (eg_perf_ctx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- output ready
  logic rdy_rand = 1'b0;
  always @(posedge nvdla_core_clk) begin
    #1;
    if (rdy_rand) eg_out_prdy = ($urandom_range(0, 3) != 0);
    else          eg_out_prdy = 1'b1;
  end

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  logic          sb_en     = 1'b1;
  int            out_count = 0;

  always @(negedge nvdla_core_clk) begin : sb_mon
    logic [EW-1:0] e;
    if (sb_en && nvdla_core_rstn && eg_out_pvld && eg_out_prdy) begin
      out_count++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_beat", {eg_out_pd, eg_out_last, eg_out_layer_end}, e);
      end
    end
  end

  // Output must hold valid and payload for as long as it is stalled.
  logic          held_v = 1'b0;
  logic [EW-1:0] held   = '0;
  always @(negedge nvdla_core_clk) begin
    if (nvdla_core_rstn && held_v)
      check("stall_hold", {eg_out_pvld, eg_out_pd, eg_out_last, eg_out_layer_end}, {1'b1, held});
    held_v = nvdla_core_rstn && eg_out_pvld && !eg_out_prdy;
    held   = {eg_out_pd, eg_out_last, eg_out_layer_end};
  end

  task automatic push_exp(input int n, input logic [DW-1:0] base, input logic layer);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = base + DW'(i);
      exp_q.push_back({d, (i == n - 1), layer && (i == n - 1)});
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // All drivers are entered and left at posedge+1.
  task automatic drive_ctx(input logic [15:0] ctx);
    logic ok;
    ok = 1'b0;
    cq2eg_pvld = 1'b1;
    cq2eg_pd   = ctx;
    for (int i = 0; i < TMO; i++) begin
      @(negedge nvdla_core_clk);
      if (cq2eg_prdy) begin ok = 1'b1; break; end
    end
    check("ctx_pop_timeout", ok, 1);
    @(posedge nvdla_core_clk); #1;
    cq2eg_pvld = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [DW-1:0] base);
    logic ok;
    for (int b = 0; b < n; b++) begin
      ok = 1'b0;
      dma_rd_rsp_pvld = 1'b1;
      dma_rd_rsp_pd   = base + DW'(b);
      for (int i = 0; i < TMO; i++) begin
        @(negedge nvdla_core_clk);
        if (dma_rd_rsp_prdy) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check("beat_accept_timeout", ok, 1);
        break;
      end
      @(posedge nvdla_core_clk); #1;
    end
    dma_rd_rsp_pvld = 1'b0;
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge nvdla_core_clk);
      if (exp_q.size() == 0 && eg_idle) begin ok = 1'b1; break; end
    end
    check("drain_timeout", ok, 1);
    @(posedge nvdla_core_clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_pvld"},  eg_out_pvld, 0);
    check({tag, "_out_last"},  eg_out_last, 0);
    check({tag, "_layer_end"}, eg_out_layer_end, 0);
    check({tag, "_out_pd"},    eg_out_pd, 0);
    check({tag, "_cq_prdy"},   cq2eg_prdy, 1);
    check({tag, "_rsp_prdy"},  dma_rd_rsp_prdy, 0);
    check({tag, "_idle"},      eg_idle, 1);
    check({tag, "_perf_b"},    eg_perf_beats, 0);
    check({tag, "_perf_c"},    eg_perf_ctx, 0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [15:0] ctx;
    int          exp_beats;
    logic        exp_layer_end;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  initial begin : main
    logic [DW-1:0] base;
    int            cnt0;

    vecs[0] = '{ctx: 16'h00FF, exp_beats: 256,  exp_layer_end: 1'b0};
    vecs[1] = '{ctx: 16'h0000, exp_beats: 1,    exp_layer_end: 1'b0};
    vecs[2] = '{ctx: 16'h7002, exp_beats: 3,    exp_layer_end: 1'b0};
    vecs[3] = '{ctx: 16'h8004, exp_beats: 5,    exp_layer_end: 1'b1};
    vecs[4] = '{ctx: 16'h0FFF, exp_beats: 4096, exp_layer_end: 1'b0};

    // Reset state
    repeat (2) @(negedge nvdla_core_clk);
    check_reset_values("rst");
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk); #1;

    // Beats held upstream while no context is present
    base = 32'h1000_0000;
    push_exp(4, base, 1'b0);
    dma_rd_rsp_pvld = 1'b1;
    dma_rd_rsp_pd   = base;
    for (int i = 0; i < 3; i++) begin
      @(negedge nvdla_core_clk);
      check("no_ctx_rsp_prdy", dma_rd_rsp_prdy, 0);
      @(posedge nvdla_core_clk); #1;
    end

    // Context 0x0003: pop at N, beats accepted N+1..N+4, outputs N+2..N+5
    cq2eg_pvld = 1'b1;
    cq2eg_pd   = 16'h0003;
    @(negedge nvdla_core_clk);
    check("t1_pop_cq_prdy", cq2eg_prdy, 1);
    check("t1_pop_rsp_prdy", dma_rd_rsp_prdy, 0);
    @(posedge nvdla_core_clk); #1;
    cq2eg_pvld = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge nvdla_core_clk);
      check("t1_rsp_prdy", dma_rd_rsp_prdy, 1);
      check("t1_out_pvld", eg_out_pvld, (b > 0));
      check("t1_cq_prdy_fin", cq2eg_prdy, (b == 3));
      @(posedge nvdla_core_clk); #1;
      if (b < 3) dma_rd_rsp_pd = base + DW'(b + 1);
      else       dma_rd_rsp_pvld = 1'b0;
    end
    @(negedge nvdla_core_clk);
    check("t1_last_out_pvld", eg_out_pvld, 1);
    check("t1_last_rsp_prdy", dma_rd_rsp_prdy, 0);
    check("t1_not_idle", eg_idle, 0);
    @(negedge nvdla_core_clk);
    check("t1_idle", eg_idle, 1);
    check("t1_out_empty", eg_out_pvld, 0);
    @(posedge nvdla_core_clk); #1;

    // Back-to-back contexts 0x8000, 0x0001: pop with fin, no bubble
    base = 32'h2000_0000;
    push_exp(1, base, 1'b1);
    push_exp(2, base + 1, 1'b0);
    fork
      begin
        drive_ctx(16'h8000);
        drive_ctx(16'h0001);
      end
      send_beats(3, base);
      begin : b2b_mon
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge nvdla_core_clk);
          if (dma_rd_rsp_pvld && dma_rd_rsp_prdy) begin ok = 1'b1; break; end
        end
        check("b2b_first_accept", ok, 1);
        check("b2b_pop_with_fin", {cq2eg_pvld, cq2eg_prdy}, 2'b11);
        for (int i = 0; i < 2; i++) begin
          @(negedge nvdla_core_clk);
          check("b2b_no_bubble_rsp", dma_rd_rsp_prdy, 1);
          check("b2b_no_bubble_out", eg_out_pvld, 1);
        end
      end
    join
    wait_drain();

`ifdef SDP_BRDMA_EG_PERF_EN
    check("perf_ctx", eg_perf_ctx, 3);
    check("perf_beats", eg_perf_beats, 7);
`else
    check("perf_ctx_off", eg_perf_ctx, 0);
    check("perf_beats_off", eg_perf_beats, 0);
`endif

    // Table of contexts under random output stalls
    rdy_rand = 1'b1;
    for (int v = 0; v < 5; v++) begin
      base = $urandom;
      cnt0 = out_count;
      push_exp(vecs[v].exp_beats, base, vecs[v].exp_layer_end);
      fork
        drive_ctx(vecs[v].ctx);
        send_beats(vecs[v].exp_beats, base);
      join
      wait_drain();
      check("vec_beat_count", out_count - cnt0, vecs[v].exp_beats);
    end
    rdy_rand = 1'b0;
    repeat (2) @(posedge nvdla_core_clk);
    #1;

    // Reset after 2 of 4 beats discards context and output beat
    sb_en = 1'b0;
    exp_q.delete();
    fork
      drive_ctx(16'h0003);
      send_beats(2, 32'h3000_0000);
    join
    nvdla_core_rstn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge nvdla_core_clk);
    check_reset_values("mid_rst_clk");
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk); #1;

    sb_en = 1'b1;
    cnt0  = out_count;
    base  = 32'h4000_0000;
    push_exp(1, base, 1'b0);
    fork
      drive_ctx(16'h0000);
      send_beats(1, base);
    join
    wait_drain();
    check("post_rst_count", out_count - cnt0, 1);
    check("post_rst_idle", eg_idle, 1);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdp_brdma_eg_unpack.md
# sdp_brdma_eg_unpack

Egress stage of the SDP bias-read DMA (BRDMA), directly downstream of the 128x16 context queue. Pops one 16-bit context per DMA request and uses it to frame the matching DMA read-response beats, forwarding them through one output register stage with per-request `last` and per-layer `layer_end` markers. Emits an idle indication for the block-level clock-gating enable.

## Interface
Parameters:
- `DW`, 512: DMA response / output data width.
- `CTX_W`, 16: context width, fixed to the queue width.

Ports:
- `nvdla_core_clk`  in  1  core clock; the only clock.
- `nvdla_core_rstn`  in  1  asynchronous active-low reset.
- `cq2eg_pvld`  in  1  context valid from the queue.
- `cq2eg_prdy`  out  1  context pop.
- `cq2eg_pd`  in  16  context: [11:0] beats−1, [14:12] reserved (ignored), [15] last request of layer.
- `dma_rd_rsp_pvld`  in  1  response beat valid.
- `dma_rd_rsp_prdy`  out  1  response beat accept.
- `dma_rd_rsp_pd`  in  DW  response data.
- `eg_out_pvld`  out  1  output valid.
- `eg_out_prdy`  in  1  output ready.
- `eg_out_pd`  out  DW  output data.
- `eg_out_last`  out  1  final beat of the current request.
- `eg_out_layer_end`  out  1  final beat of the layer.
- `eg_idle`  out  1  no context held and output register empty.
- `eg_perf_beats`  out  32  accepted-beat counter.
- `eg_perf_ctx`  out  32  popped-context counter.

## Operation
- FSM states:
  - IDLE: no context held.
  - STREAM: context held; `beat_cnt` (12 b) holds the remaining beats minus one; `layer_flag` (1 b) holds ctx[15].
- Output register (`out_vld`, data, `last`, `layer_end`) is a single stage.
  - `pipe_free = !out_vld || eg_out_prdy`.
- `dma_rd_rsp_prdy = (state==STREAM) && pipe_free`.
- `beat_acc = dma_rd_rsp_pvld && dma_rd_rsp_prdy`.
- `fin = beat_acc && beat_cnt==0`.
- `cq2eg_prdy = (state==IDLE) || fin`. This allows back-to-back contexts with no bubble.
- Context pop (`cq2eg_pvld && cq2eg_prdy`):
  - load `beat_cnt = pd[11:0]` and `layer_flag = pd[15]`;
  - state becomes STREAM.
- On `beat_acc`:
  - load the output register with data;
  - `last = (beat_cnt==0)`, `layer_end = layer_flag && (beat_cnt==0)`;
  - `out_vld` is set;
  - `beat_cnt` decrements unless `fin`.
- `fin` without a same-cycle pop → IDLE. `fin` with a same-cycle pop → remain STREAM with the new context loaded.
- If `eg_out_prdy` is high and there is no `beat_acc`, `out_vld` clears.
- Response beats are never accepted in IDLE; they are held upstream.
- A context of 0 (one beat) is legal; 0xFFF gives 4096 beats.
- Output data, `last` and `layer_end` are held stable while `eg_out_pvld && !eg_out_prdy`.
- `eg_idle = (state==IDLE) && !out_vld`.

## Timing
- Reset values:
  - state IDLE, `beat_cnt` 0, `layer_flag` 0;
  - `eg_out_pvld` 0, `eg_out_last` 0, `eg_out_layer_end` 0, `eg_out_pd` 0;
  - perf counters 0;
  - `cq2eg_prdy` 1, `dma_rd_rsp_prdy` 0, `eg_idle` 1.
- Context pop at cycle N → earliest beat accept at N+1.
- Beat accepted at cycle N → `eg_out_pvld` at N+1.
- Full throughput is one beat per cycle with `eg_out_prdy` held high, including across context boundaries.
- `dma_rd_rsp_prdy` and `cq2eg_prdy` depend combinationally on `eg_out_prdy`. There is no combinational path from `*_pvld` to the same interface's `*_prdy`.
- Reset asserted mid-request discards the held context and output beat. The upstream queue must be reset in the same reset domain.

## Configuration
- `SDP_BRDMA_EG_PERF_EN` defined:
  - `eg_perf_beats` increments on each `beat_acc`;
  - `eg_perf_ctx` increments on each context pop;
  - both are 32 b and saturate at 0xFFFFFFFF.
- `SDP_BRDMA_EG_PERF_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `sdp_brdma_pkg`:
  - context field constants (`CTX_BEATS_MSB=11`, `CTX_LAYER_BIT=15`);
  - state encoding (IDLE=0, STREAM=1);
  - default `DW`.
- One sub-module, `sdp_brdma_eg_pipe`: a single-stage valid/ready output register carrying {data, last, layer_end}.
- The FSM and beat counter live in the top module.

## Test plan
- Context 0x0003, 4 beats streamed, `eg_out_prdy`=1 → outputs at cycles 2–5; `last` only on the 4th beat; `layer_end`=0; then `eg_idle`=1.
- Contexts 0x8000 then 0x0001 queued back-to-back, 3 beats → second pop in the same cycle as the first `fin`; beat 1 has `last`=1 and `layer_end`=1; beat 3 has `last`=1 and `layer_end`=0; no bubble.
- Beats presented before any context → `dma_rd_rsp_prdy` stays 0 until the cycle after a pop.
- Random `eg_out_prdy` stalls on context 0x00FF → exactly 256 beats with data order preserved; `last` only on beat 256; data stable during stalls.
- Reset asserted after 2 of 4 beats → all outputs return to reset values; a new context 0x0000 plus 1 beat completes normally.
- With `SDP_BRDMA_EG_PERF_EN` defined, after the first two scenarios → `eg_perf_ctx`=3, `eg_perf_beats`=7. Without the macro → both read 0.
